// File: rtl/fir_pkg.sv
// Shared sizing, rounding and saturation helpers for the parametrised
// transposed-form FIR filter family.
package fir_pkg;

  // Accumulator width that holds the sum of ntaps full-precision products.
  function automatic int fir_acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

  // Half an LSB of the Q1.(cw-1) scaled result, added before the arithmetic shift.
  function automatic longint fir_round_const(input int cw);
    return longint'(1) << (cw - 2);
  endfunction

  function automatic longint fir_sat_max(input int dw);
    return (longint'(1) << (dw - 1)) - 1;
  endfunction

  function automatic longint fir_sat_min(input int dw);
    return -(longint'(1) << (dw - 1));
  endfunction

endpackage

// File: rtl/fir_tf_tap.sv
// One transposed-form slice: registers x*b + s_in when the shared sample
// valid is high, holds otherwise.
module fir_tf_tap
  import fir_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = fir_acc_width(DW, CW, 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] x,
  input  logic signed [CW-1:0] b,
  input  logic signed [AW-1:0] s_in,
  output logic signed [AW-1:0] s_out
);

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] b_ext;

  // Widen both operands first so the product and the add are exact at AW bits.
  assign x_ext = AW'(x);
  assign b_ext = AW'(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_out <= '0;
    end else if (en) begin
      s_out <= x_ext * b_ext + s_in;
    end
  end

endmodule

// File: rtl/fir_tf_param.sv
// Parametrised transposed-form FIR with a writable coefficient file and
// rounded Q1.(CW-1) output; define FIR_SAT_EN for saturating output.
module fir_tf_param
  import fir_pkg::*;
#(
  parameter  int NTAPS = 11,
  parameter  int DW    = 8,
  parameter  int CW    = 8,
  localparam int CAW   = $clog2(NTAPS),
  localparam int AW    = fir_acc_width(DW, CW, NTAPS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic signed [DW-1:0]  DIN,
  input  logic                  VIN,
  input  logic                  COEF_WE,
  input  logic [CAW-1:0]        COEF_ADDR,
  input  logic signed [CW-1:0]  COEF_DIN,
  output logic signed [DW-1:0]  DOUT,
  output logic                  VOUT
);

  // Handshake: VIN and VOUT are valid-only strobes with no ready; every VIN=1
  // edge accepts a sample and every VOUT=1 cycle must be consumed downstream.

  localparam logic signed [AW-1:0] RND = AW'(fir_round_const(CW));

  logic signed [CW-1:0] coef [NTAPS];
  logic signed [DW-1:0] x_q;
  logic                 v1;
  logic                 v2;
  logic signed [AW-1:0] s_chain [NTAPS+1];
  logic signed [AW-1:0] rnd_sum;
  logic signed [DW-1:0] fit_val;

  // Out-of-range addresses match no entry, so those writes fall through.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (COEF_WE) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (COEF_ADDR == CAW'(k)) coef[k] <= COEF_DIN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= VIN;
      if (VIN) x_q <= DIN;
    end
  end

  // s_chain[0] is y_acc; the slice past the last tap feeds in zero.
  assign s_chain[NTAPS] = '0;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    fir_tf_tap #(
      .DW (DW),
      .CW (CW),
      .AW (AW)
    ) u_tap (
      .clk   (CLK),
      .rst   (RST),
      .en    (v1),
      .x     (x_q),
      .b     (coef[k]),
      .s_in  (s_chain[k+1]),
      .s_out (s_chain[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) v2 <= 1'b0;
    else     v2 <= v1;
  end

  assign rnd_sum = s_chain[0] + RND;

`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'(fir_sat_max(DW));
  localparam logic signed [AW-1:0] SAT_MIN = AW'(fir_sat_min(DW));

  logic signed [AW-1:0] r_full;

  always_comb begin
    r_full  = rnd_sum >>> (CW - 1);
    fit_val = r_full[DW-1:0];
    if (r_full > SAT_MAX)      fit_val = SAT_MAX[DW-1:0];
    else if (r_full < SAT_MIN) fit_val = SAT_MIN[DW-1:0];
  end
`else
  // Plain two's-complement wrap to the output width.
  always_comb begin
    fit_val = DW'(rnd_sum >>> (CW - 1));
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT <= '0;
      VOUT <= 1'b0;
    end else begin
      VOUT <= v2;
      if (v2) DOUT <= fit_val;
    end
  end

endmodule
